// File: rtl/bm_frame_accum.sv
// Frame accumulator: sums FRAME_LEN unsigned samples, then holds the total until it is taken downstream.
// Result is registered on the last accept edge; in_ready is low for the whole HOLD. Macro BM_FRAME_ACCUM_SATURATE_EN clamps instead of wrapping.
module bm_frame_accum #(
  parameter int DATA_W    = 18,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W:0]   sum;
  logic             ovf_next;
  logic [ACC_W-1:0] acc_next;
  logic             accept;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  assign accept   = in_valid & in_ready;
  assign sum      = {1'b0, acc_q} + (ACC_W+1)'(in_data);
  assign ovf_next = ovf_q | sum[ACC_W];

`ifdef BM_FRAME_ACCUM_SATURATE_EN
  // Once any carry has occurred this frame the total stays pinned at full scale.
  assign acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          if (cnt_q == CNT_LAST) begin
            out_data_d  = acc_next;
            out_ovf_d   = ovf_next;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_ONE;
            ovf_d = ovf_next;
          end
        end
      end
      ST_HOLD: begin
        // clear is deliberately ignored here so a finished frame is never lost.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_bm_frame_accum.sv
// Directed bench for bm_frame_accum: reset, basic frame, backpressure, overflow, clear, gaps and mid-frame reset.
module tb_bm_frame_accum;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [17:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_ovf;

  int checks = 0;
  int failures = 0;
  int vld_cycles = 0;

`ifdef BM_FRAME_ACCUM_SATURATE_EN
  localparam logic [23:0] OVF_EXP = 24'd16777215;
`else
  localparam logic [23:0] OVF_EXP = 24'd16777088;
`endif

  bm_frame_accum #(.DATA_W(18), .ACC_W(24), .FRAME_LEN(128)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (out_valid === 1'b1) vld_cycles <= vld_cycles + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Presents n samples (base, base+inc, ...); returns 1ns after the edge that accepts the last one.
  task automatic drive_samples(input logic [17:0] base, input logic [17:0] inc,
                               input int n, input bit gapped);
    int sent = 0;
    int guard = 0;
    logic [17:0] v = base;
    bit took;
    while (sent < n && guard < 4 * n + 20) begin
      in_valid = 1'b1;
      in_data  = v;
      took     = in_ready;
      @(posedge clock); #1;
      guard++;
      if (took) begin
        sent++;
        v = v + inc;
      end
      if (gapped && sent < n) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
        guard++;
      end
    end
    in_valid = 1'b0;
    if (sent < n) begin
      checks++; failures++;
      $display("FAIL drive_timeout sent=%0d required=%0d", sent, n);
    end
  endtask

  task automatic cycle();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    drive_samples(18'd100, 18'd0, 128, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'd12800) begin failures++;
      $display("FAIL pre_reset_hold valid=%b data=%0d required valid=1 data=12800", out_valid, out_data); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    checks++; if (out_data !== 24'd0) begin failures++;
      $display("FAIL reset_out_data got=%0d required=0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin failures++;
      $display("FAIL reset_out_ovf got=%b required=0", out_ovf); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    @(negedge clock) reset_n = 1'b1;
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_basic_frame();
    int v0;
    out_ready = 1'b1;
    v0 = vld_cycles;
    drive_samples(18'd1, 18'd1, 128, 1'b0);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++;
      $display("FAIL basic_result_cycle valid=%b in_ready=%b required valid=1 in_ready=0", out_valid, in_ready); end
    checks++; if (out_data !== 24'd8256 || out_ovf !== 1'b0) begin failures++;
      $display("FAIL basic_sum data=%0d ovf=%b required data=8256 ovf=0", out_data, out_ovf); end
    cycle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL basic_after valid=%b in_ready=%b required valid=0 in_ready=1", out_valid, in_ready); end
    checks++; if (out_data !== 24'd8256) begin failures++;
      $display("FAIL basic_data_kept got=%0d required=8256", out_data); end
    cycle();
    checks++; if (vld_cycles - v0 !== 1) begin failures++;
      $display("FAIL basic_valid_width got=%0d required=1", vld_cycles - v0); end
  endtask

  task automatic test_backpressure();
    bit stable = 1'b1;
    out_ready = 1'b0;
    drive_samples(18'd4, 18'd0, 128, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 18'd7;
      clear    = i[0];
      cycle();
      if (out_valid !== 1'b1 || out_data !== 24'd512 || in_ready !== 1'b0) stable = 1'b0;
    end
    clear = 1'b0;
    checks++; if (!stable) begin failures++;
      $display("FAIL bp_hold_stable valid=%b data=%0d in_ready=%b required valid=1 data=512 in_ready=0",
               out_valid, out_data, in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL bp_release valid=%b in_ready=%b required valid=0 in_ready=1", out_valid, in_ready); end
    drive_samples(18'd1, 18'd0, 128, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'd128) begin failures++;
      $display("FAIL bp_no_count valid=%b data=%0d required valid=1 data=128", out_valid, out_data); end
    cycle();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    drive_samples(18'd262143, 18'd0, 128, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_ovf !== 1'b1) begin failures++;
      $display("FAIL ovf_flag valid=%b ovf=%b required valid=1 ovf=1", out_valid, out_ovf); end
    checks++; if (out_data !== OVF_EXP) begin failures++;
      $display("FAIL ovf_data got=%0d required=%0d", out_data, OVF_EXP); end
    cycle();
  endtask

  task automatic test_clear();
    int v0;
    out_ready = 1'b1;
    v0 = vld_cycles;
    drive_samples(18'd1000, 18'd0, 50, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL clear_partial_valid got=%b required=0", out_valid); end
    in_valid = 1'b1;
    in_data  = 18'd1000;
    clear    = 1'b1;
    cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    drive_samples(18'd2, 18'd0, 128, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'd256 || out_ovf !== 1'b0) begin failures++;
      $display("FAIL clear_frame valid=%b data=%0d ovf=%b required valid=1 data=256 ovf=0",
               out_valid, out_data, out_ovf); end
    cycle();
    checks++; if (vld_cycles - v0 !== 1) begin failures++;
      $display("FAIL clear_result_count got=%0d required=1", vld_cycles - v0); end
  endtask

  task automatic test_gapped_and_reset();
    out_ready = 1'b1;
    drive_samples(18'd5, 18'd0, 128, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'd640) begin failures++;
      $display("FAIL gapped_sum valid=%b data=%0d required valid=1 data=640", out_valid, out_data); end
    cycle();
    drive_samples(18'd7, 18'd0, 60, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL midframe_reset valid=%b in_ready=%b required valid=0 in_ready=1", out_valid, in_ready); end
    @(negedge clock) reset_n = 1'b1;
    cycle();
    drive_samples(18'd3, 18'd0, 128, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 24'd384) begin failures++;
      $display("FAIL post_reset_frame valid=%b data=%0d required valid=1 data=384", out_valid, out_data); end
    cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    cycle();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_overflow();
    test_clear();
    test_gapped_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
